// File: rtl/ahb_lite_master_usb_pkg.sv
// ============================================================================
// usb_ahb_pkg : AHB-Lite constants and master state encoding
// Revision    : 1.0
// ============================================================================
`default_nettype none

package usb_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;

    localparam logic [1:0] HSIZE_BYTE = 2'd0;
    localparam logic [1:0] HSIZE_HALF = 2'd1;
    localparam logic [1:0] HSIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } master_state_e;

endpackage

`default_nettype wire

// File: rtl/ahb_lite_master_usb_if.sv
// ============================================================================
// ahb_lite_master_usb_if : command/response and AHB-Lite bus bundle
// Revision               : 1.0
// ============================================================================
`default_nettype none

interface ahb_lite_master_usb_if #(
    parameter int ADDR_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [1:0]        cmd_size;
    logic [31:0]       cmd_wdata;

    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_error;
    logic              rsp_timeout;

    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic [1:0]        hsize;
    logic              hwrite;
    logic [31:0]       hwdata;
    logic [31:0]       hrdata;
    logic              hready;
    logic              hresp;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  hrdata, hready, hresp,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        output hsel, haddr, htrans, hsize, hwrite, hwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output hrdata, hready, hresp,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        input  hsel, haddr, htrans, hsize, hwrite, hwdata
    );

endinterface

`default_nettype wire

// File: rtl/ahb_lite_master_usb_wait_timer.sv
// ============================================================================
// ahb_wait_timer : saturating data-phase wait-state counter with limit flag
// Revision       : 1.0
// ============================================================================
`default_nettype none

module ahb_wait_timer #(
    parameter int LIMIT = 16,
    parameter int CNT_W = 5
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic inc,
    output logic limit_reached
);

    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != C_LIMIT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Flags the wait cycle whose increment brings the count up to LIMIT.
    assign limit_reached = inc && (r_count >= C_LAST);

endmodule

`default_nettype wire

// File: rtl/ahb_lite_master_usb.sv
// ============================================================================
// ahb_lite_master_usb : single-outstanding AHB-Lite initiator for USB regs
// Revision            : 1.0
// ============================================================================
`default_nettype none

module ahb_lite_master_usb
    import usb_ahb_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    ahb_lite_master_usb_if.master bus
);

    localparam int         C_CNT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ADDR  = ADDR;
    localparam logic [1:0] S_DATA  = DATA;
    localparam logic [1:0] S_RESP  = RESP;

    logic [1:0]        r_state;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_error;
    logic              r_rsp_timeout;

    logic w_accept;
    logic w_wait;
    logic w_limit;
    logic w_err_now;

    assign w_accept  = (r_state == S_IDLE) && bus.cmd_valid;
    assign w_wait    = (r_state == S_DATA) && !bus.hready;
    assign w_err_now = r_err | bus.hresp;

    ahb_wait_timer #(
        .LIMIT (WAIT_LIMIT),
        .CNT_W (C_CNT_W)
    ) u_wait_timer (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (w_accept),
        .inc           (w_wait),
        .limit_reached (w_limit)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= S_IDLE;
            r_write       <= 1'b0;
            r_addr        <= '0;
            r_size        <= 2'd0;
            r_wdata       <= 32'd0;
            r_err         <= 1'b0;
            r_rsp_rdata   <= 32'd0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_write <= bus.cmd_write;
                        r_addr  <= bus.cmd_addr;
                        r_size  <= bus.cmd_size;
                        r_wdata <= bus.cmd_wdata;
                        r_err   <= 1'b0;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (bus.hready) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bus.hready) begin
                        // hrdata is only looked at for clean reads
                        r_rsp_rdata   <= (!r_write && !w_err_now) ? bus.hrdata : 32'd0;
                        r_rsp_error   <= w_err_now;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= S_RESP;
                    end else if (w_limit) begin
                        r_rsp_rdata   <= 32'd0;
                        r_rsp_error   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= S_RESP;
                    end else if (bus.hresp) begin
                        r_err <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Bus outputs decode only from state and the command latch.
    assign bus.cmd_ready   = (r_state == S_IDLE);
    assign bus.rsp_valid   = (r_state == S_RESP);
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_error   = r_rsp_error;
    assign bus.rsp_timeout = r_rsp_timeout;

    assign bus.hsel   = (r_state == S_ADDR);
    assign bus.htrans = (r_state == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.haddr  = (r_state == S_ADDR) ? r_addr : '0;
    assign bus.hsize  = (r_state == S_ADDR) ? r_size : 2'd0;
    assign bus.hwrite = (r_state == S_ADDR) ? r_write : 1'b0;
    assign bus.hwdata = ((r_state == S_DATA) && r_write) ? r_wdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_master_usb.sv
// ============================================================================
// tb_ahb_lite_master_usb : directed scoreboard bench for ahb_lite_master_usb
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_ahb_lite_master_usb;
    import usb_ahb_pkg::*;

    localparam int ADDR_W     = 4;
    localparam int WAIT_LIMIT = 16;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        timeout;
    } rsp_t;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_rsp    = 0;
    rsp_t exp_q[$];

    ahb_lite_master_usb_if #(.ADDR_W(ADDR_W)) bus_if ();

    ahb_lite_master_usb #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic rsp_t mk(input logic [31:0] r, input logic e, input logic t);
        rsp_t x;
        x.rdata   = r;
        x.error   = e;
        x.timeout = t;
        return x;
    endfunction

    // Monitor: every rsp_valid pulse is matched against the oldest expectation.
    always @(negedge clk) begin : monitor
        rsp_t e;
        if (bus_if.rsp_valid === 1'b1) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected none at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata",   bus_if.rsp_rdata,   e.rdata);
                chk("rsp_error",   bus_if.rsp_error,   e.error);
                chk("rsp_timeout", bus_if.rsp_timeout, e.timeout);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Presents a command and returns 1ns into the ADDR cycle (cycle 1).
    task automatic issue(input logic w, input logic [3:0] a, input logic [1:0] s, input logic [31:0] d);
        bit done;
        done = 1'b0;
        cyc();
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = w;
        bus_if.cmd_addr  = a;
        bus_if.cmd_size  = s;
        bus_if.cmd_wdata = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus_if.cmd_ready === 1'b1) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: got cmd_ready=0 for 50 cycles expected 1");
        end
        cyc();
        bus_if.cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int rsp_before;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = '0;
        bus_if.cmd_size  = 2'd0;
        bus_if.cmd_wdata = 32'd0;
        bus_if.hrdata    = 32'd0;
        bus_if.hready    = 1'b1;
        bus_if.hresp     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", bus_if.cmd_ready, 1);
        chk("rst_htrans",    bus_if.htrans,    HTRANS_IDLE);
        chk("rst_hsel",      bus_if.hsel,      0);
        chk("rst_rsp_valid", bus_if.rsp_valid, 0);
        chk("rst_rsp_error", bus_if.rsp_error, 0);
        @(negedge clk);
        n_rst = 1'b1;

        // Word write, zero wait states
        exp_q.push_back(mk(32'h0, 1'b0, 1'b0));
        issue(1'b1, 4'h0, HSIZE_WORD, 32'hDEADBEEF);
        smp();
        chk("t1_htrans",    bus_if.htrans,    HTRANS_NONSEQ);
        chk("t1_hsel",      bus_if.hsel,      1);
        chk("t1_hwrite",    bus_if.hwrite,    1);
        chk("t1_haddr",     bus_if.haddr,     0);
        chk("t1_hsize",     bus_if.hsize,     HSIZE_WORD);
        chk("t1_cmd_ready", bus_if.cmd_ready, 0);
        cyc(); smp();
        chk("t1_data_htrans", bus_if.htrans, HTRANS_IDLE);
        chk("t1_hwdata",      bus_if.hwdata, 32'hDEADBEEF);
        cyc(); smp();
        chk("t1_rsp_valid_c3", bus_if.rsp_valid, 1);
        cyc(); smp();
        chk("t1_rsp_valid_c4", bus_if.rsp_valid, 0);
        chk("t1_cmd_ready_c4", bus_if.cmd_ready, 1);

        // Read with three wait states
        exp_q.push_back(mk(32'h5, 1'b0, 1'b0));
        issue(1'b0, 4'h4, HSIZE_WORD, 32'hFFFFFFFF);
        smp();
        chk("t2_hwrite", bus_if.hwrite, 0);
        chk("t2_haddr",  bus_if.haddr,  4'h4);
        for (int c = 2; c <= 6; c++) begin
            cyc();
            if (c == 2) bus_if.hready = 1'b0;
            if (c == 5) begin
                bus_if.hready = 1'b1;
                bus_if.hrdata = 32'h00000005;
            end
            smp();
            if (c == 2) chk("t2_hwdata_read", bus_if.hwdata, 0);
            chk("t2_rsp_valid", bus_if.rsp_valid, (c == 6));
        end

        // Two-cycle ERROR response on a byte write
        exp_q.push_back(mk(32'h0, 1'b1, 1'b0));
        issue(1'b1, 4'h6, HSIZE_BYTE, 32'h000000A5);
        smp();
        chk("t3_hsize", bus_if.hsize, HSIZE_BYTE);
        for (int c = 2; c <= 5; c++) begin
            cyc();
            if (c == 2) begin bus_if.hresp = 1'b1; bus_if.hready = 1'b0; end
            if (c == 3) bus_if.hready = 1'b1;
            if (c == 4) bus_if.hresp = 1'b0;
            smp();
            chk("t3_rsp_valid", bus_if.rsp_valid, (c == 4));
            chk("t3_cmd_ready", bus_if.cmd_ready, (c == 5));
        end

        // Back-to-back: cmd_valid held for a write then a read
        bus_if.hrdata = 32'h12345678;
        exp_q.push_back(mk(32'h0, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h12345678, 1'b0, 1'b0));
        rsp_before = n_rsp;
        issue(1'b1, 4'hC, HSIZE_HALF, 32'h0000C0DE);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = 4'h0;
        bus_if.cmd_size  = HSIZE_WORD;
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) cyc();
            if (c == 5) bus_if.cmd_valid = 1'b0;
            smp();
            chk("t5_htrans", bus_if.htrans, (c == 1 || c == 5) ? HTRANS_NONSEQ : HTRANS_IDLE);
            if (c == 1) chk("t5_haddr_wr", bus_if.haddr, 4'hC);
            if (c == 5) chk("t5_hwrite_rd", bus_if.hwrite, 0);
            chk("t5_rsp_valid", bus_if.rsp_valid, (c == 3 || c == 7));
        end
        cyc(); smp();
        chk("t5_rsp_count", n_rsp - rsp_before, 2);

        // Wait-state timeout
        bus_if.hrdata = 32'hBAD0BAD0;
        exp_q.push_back(mk(32'h0, 1'b1, 1'b1));
        issue(1'b0, 4'h8, HSIZE_WORD, 32'h0);
        smp();
        for (int c = 2; c <= 19; c++) begin
            cyc();
            if (c == 2)  bus_if.hready = 1'b0;
            if (c == 19) bus_if.hready = 1'b1;
            smp();
            chk("t4_rsp_valid", bus_if.rsp_valid, (c == 18));
            if (c == 18) begin
                chk("t4_htrans", bus_if.htrans, HTRANS_IDLE);
                chk("t4_hsel",   bus_if.hsel,   0);
            end
            if (c == 19) chk("t4_cmd_ready", bus_if.cmd_ready, 1);
        end

        // Reset asserted during a data-phase wait state
        rsp_before = n_rsp;
        issue(1'b1, 4'h4, HSIZE_WORD, 32'h5555AAAA);
        smp();
        cyc();
        bus_if.hready = 1'b0;
        smp();
        chk("t6_hwdata_pre", bus_if.hwdata, 32'h5555AAAA);
        cyc();
        #2;
        n_rst = 1'b0;
        #1;
        chk("t6_cmd_ready",   bus_if.cmd_ready,   1);
        chk("t6_hwdata",      bus_if.hwdata,      0);
        chk("t6_htrans",      bus_if.htrans,      HTRANS_IDLE);
        chk("t6_rsp_valid",   bus_if.rsp_valid,   0);
        chk("t6_rsp_error",   bus_if.rsp_error,   0);
        chk("t6_rsp_timeout", bus_if.rsp_timeout, 0);
        chk("t6_rsp_rdata",   bus_if.rsp_rdata,   0);
        bus_if.hready = 1'b1;
        @(negedge clk);
        #2;
        n_rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc(); smp();
        end
        chk("t6_no_rsp", n_rsp - rsp_before, 0);
        chk("t6_idle_ready", bus_if.cmd_ready, 1);

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ahb_lite_master_usb.md
Name: ahb_lite_master_usb

Overview:
Single-outstanding AHB-Lite initiator that drives the USB endpoint slave's register bus from a simple command/response interface. Used by the SoC-side controller model and integration benches to issue register reads and writes. Handles wait states, two-cycle ERROR responses and a wait-state timeout. Issues one transfer at a time, with htrans IDLE between transfers. It does not pipeline.

Parameters:
WAIT_LIMIT, 16, number of consecutive hready=0 data-phase cycles after which the transfer is aborted as timed out
ADDR_W, 4, AHB address width

Ports:
clk  in  1  system clock, all state updates on its rising edge
n_rst  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted this cycle when high together with cmd_valid
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target register address
cmd_size  in  2  hsize encoding: 0 = byte, 1 = half-word, 2 = word
cmd_wdata  in  32  write data
rsp_valid  out  1  one-cycle pulse: transfer finished
rsp_rdata  out  32  read data, valid with rsp_valid for reads; 0 for writes
rsp_error  out  1  slave returned hresp=1, or timeout; qualified by rsp_valid
rsp_timeout  out  1  abort was caused by WAIT_LIMIT; qualified by rsp_valid
hsel  out  1  slave select
haddr  out  ADDR_W  address
htrans  out  2  0 = IDLE, 2 = NONSEQ only
hsize  out  2  transfer size
hwrite  out  1  direction
hwdata  out  32  write data, data phase
hrdata  in  32  read data from slave
hready  in  1  slave ready / phase completion
hresp  in  1  slave error response

Behaviour:
- Reset is asynchronous, active-low.
  - State goes to IDLE; latched command and all outputs are cleared to 0, except cmd_ready, which is 1.
  - Reset mid-transfer abandons the transfer silently; no rsp_valid is produced.
- All outputs are registered or decoded from the state register and latched command. There are no combinational paths from AHB inputs to AHB outputs.
- IDLE state:
  - cmd_ready=1.
  - On cmd_valid=1, latch write/addr/size/wdata, clear the wait counter and the error flag, then go to ADDR.
- ADDR state (address phase):
  - hsel=1, htrans=2, and haddr/hsize/hwrite are driven from the latch; cmd_ready=0.
  - Advance to DATA on a clock edge where hready=1; otherwise hold ADDR.
- DATA state (data phase):
  - hsel=0, htrans=0; hwdata is driven from the latched wdata for writes, 0 for reads.
  - Each cycle with hready=0 increments the wait counter. The counter is ceil(log2(WAIT_LIMIT+1)) bits wide and saturates.
  - hresp=1 with hready=0: set the sticky error flag and stay in DATA (first cycle of ERROR).
  - hready=1: capture hrdata (reads only); the error flag |= hresp. Go to RESP.
  - Wait counter reaches WAIT_LIMIT with hready still 0: go to RESP with rsp_error=1 and rsp_timeout=1, and leave the data phase by forcing the bus outputs idle.
- RESP state:
  - rsp_valid=1 for exactly one cycle, with rsp_rdata/rsp_error/rsp_timeout.
  - cmd_ready=0; return to IDLE next cycle.
- Response outputs keep their values until the next RESP; only rsp_valid is a pulse.
- Nominal latency with zero wait states:
  - accept at edge 0, ADDR in cycle 1, DATA in cycle 2, rsp_valid in cycle 3;
  - next command is accepted in cycle 4.
- A cmd_valid arriving while not in IDLE is ignored; the source must hold it until it sees cmd_ready.
- hrdata is never sampled on write transfers. rsp_rdata is 0 for writes and for errored reads.
- cmd_size=3 is passed through unchanged. The slave is responsible for erroring it.

Decomposition:
- Package usb_ahb_pkg holds:
  - the htrans constants HTRANS_IDLE=2'd0 and HTRANS_NONSEQ=2'd2;
  - the hsize constants;
  - the master state enum {IDLE, ADDR, DATA, RESP}.
- One sub-module is natural: ahb_wait_timer, the saturating wait-state counter with a clear input and a limit-reached flag.

Test Plan:
- Word write, hready always 1: cmd addr=4'h0, wdata=32'hDEADBEEF, size=2.
  - Expect htrans=2/hwrite=1/haddr=0 in cycle 1 and hwdata=DEADBEEF in cycle 2.
  - Expect rsp_valid in cycle 3 with rsp_error=0.
- Read with 3 wait states: addr=4'h4, slave holds hready=0 for 3 data cycles, then returns hrdata=32'h00000005.
  - Expect rsp_valid 3 cycles later than nominal, with rsp_rdata=5 and rsp_error=0.
- Error response: write addr=4'h6.
  - Slave gives hresp=1/hready=0, then hresp=1/hready=1.
  - Expect rsp_error=1, rsp_timeout=0, and a return to IDLE with cmd_ready=1 the cycle after rsp_valid.
- Timeout: WAIT_LIMIT=16, slave holds hready=0 indefinitely in the data phase.
  - Expect rsp_valid after 16 wait cycles with rsp_error=1 and rsp_timeout=1; the bus returns to htrans=0.
- Back-to-back: cmd_valid held high for two commands (write 4'hC, then read 4'h0).
  - Expect htrans=0 in the cycles between the two NONSEQ phases and exactly two rsp_valid pulses.
- Reset mid-DATA: assert n_rst=0 during a wait state.
  - Expect all outputs 0 immediately and cmd_ready=1; no rsp_valid after reset is released.
